display_arbiter: RTL and testbench

- Shares the 4-digit seven-segment display between three requesters using REQ/GNT handshakes.
- Grant order is round-robin, each grant holds for a minimum time, and ownership changes are blanked for one cycle.
- Drives the EN mask and D3..D0 digit inputs of the downstream seven-segment scan controller.
- Provides per-requester blinking, timed in 1 ms strobes.

---
 rtl/display_arbiter.sv | 142 ++++++++++++++
 tb/tb_display_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner arbitration of a 4-digit seven-segment display with hold time, blanking and blink
module display_arbiter #(
    parameter int HOLD_MS  = 1000,
    parameter int BLINK_MS = 250,
    parameter int CW       = 10
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        tick_1ms_i,
    input  logic [2:0]  req_i,
    input  logic [15:0] data0_i,
    input  logic [15:0] data1_i,
    input  logic [15:0] data2_i,
    input  logic [3:0]  enm0_i,
    input  logic [3:0]  enm1_i,
    input  logic [3:0]  enm2_i,
    input  logic [2:0]  blink_i,
    output logic [2:0]  gnt_o,
    output logic        busy_o,
    output logic [3:0]  en_o,
    output logic [3:0]  d3_o,
    output logic [3:0]  d2_o,
    output logic [3:0]  d1_o,
    output logic [3:0]  d0_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, SWITCH = 2'd2} state_t;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_MS - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_MS - 1);

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d, sw_ptr;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d, blink_cnt_q, blink_cnt_d;
    logic          hold_done_q, hold_done_d, phase_q, phase_d;
    logic [2:0]    gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [3:0]    en_q, en_d, enm_sel;
    logic [15:0]   d_q, d_d, data_sel;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // First requester at or after p, wrapping modulo 3
    function automatic logic [1:0] pick(input logic [1:0] p, input logic [2:0] r);
        logic [1:0] p1, p2;
        p1 = inc3(p);
        p2 = inc3(p1);
        return r[p] ? p : (r[p1] ? p1 : p2);
    endfunction

    // Ownership FSM with hold and blink timers that run only while granted
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        sw_ptr      = inc3(owner_q);
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    owner_d = pick(rr_ptr_q, req_i);
                end
            end
            GRANT: begin
                if (!req_i[owner_q] || (hold_done_q && |(req_i & ~(3'b001 << owner_q))))
                    state_d = SWITCH;
                if (tick_1ms_i) begin
                    if (!hold_done_q) begin
                        hold_done_d = (hold_cnt_q == HOLD_LAST);
                        hold_cnt_d  = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CW'(1);
                    end
                    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + CW'(1);
                    phase_d     = (blink_cnt_q == BLINK_LAST) ? !phase_q : phase_q;
                end
            end
            SWITCH: begin
                rr_ptr_d = sw_ptr;
                state_d  = (|req_i) ? GRANT : IDLE;
                owner_d  = (|req_i) ? pick(sw_ptr, req_i) : owner_q;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT && state_q != GRANT) begin
            hold_cnt_d  = '0;
            hold_done_d = 1'b0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end
    end

    // Grant follows state one cycle later; EN/D follow the registered grant one cycle after that
    always_comb begin
        gnt_d    = (state_q == GRANT) ? (3'b001 << owner_q) : 3'b000;
        busy_d   = (state_q == GRANT);
        data_sel = (owner_q == 2'd2) ? data2_i : ((owner_q == 2'd1) ? data1_i : data0_i);
        enm_sel  = (owner_q == 2'd2) ? enm2_i : ((owner_q == 2'd1) ? enm1_i : enm0_i);
        en_d     = (|gnt_q && !(blink_i[owner_q] && !phase_q)) ? enm_sel : 4'h0;
        d_d      = (|gnt_q) ? data_sel : d_q;
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            gnt_q       <= 3'b000;
            busy_q      <= 1'b0;
            en_q        <= 4'h0;
            d_q         <= 16'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            en_q        <= en_d;
            d_q         <= d_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;
    assign en_o   = en_q;
    assign d3_o   = d_q[15:12];
    assign d2_o   = d_q[11:8];
    assign d1_o   = d_q[7:4];
    assign d0_o   = d_q[3:0];
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: scoreboard bench for display_arbiter with a reference model and directed scenarios
module tb_display_arbiter;
    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic        clk = 1'b0;
    logic        rst_n, tick;
    logic [2:0]  req, blink;
    logic [15:0] data0, data1, data2;
    logic [3:0]  enm0, enm1, enm2;
    logic [2:0]  gnt_o;
    logic        busy_o;
    logic [3:0]  en_o, d3_o, d2_o, d1_o, d0_o;

    int n_vec = 0;
    int n_err = 0;

    display_arbiter #(.HOLD_MS(HOLD), .BLINK_MS(BLINK), .CW(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .tick_1ms_i(tick), .req_i(req),
        .data0_i(data0), .data1_i(data1), .data2_i(data2),
        .enm0_i(enm0), .enm1_i(enm1), .enm2_i(enm2), .blink_i(blink),
        .gnt_o(gnt_o), .busy_o(busy_o), .en_o(en_o),
        .d3_o(d3_o), .d2_o(d2_o), .d1_o(d1_o), .d0_o(d0_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model, written from the behavioural description
    int          m_st, m_own, m_rr, m_hc, m_bc;
    logic        m_hd, m_ph, m_busy;
    logic [2:0]  m_gnt;
    logic [3:0]  m_en;
    logic [15:0] m_d;
    logic [23:0] sb[$];

    function automatic int rr_pick(int p, logic [2:0] r);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return p;
    endfunction

    function automatic logic [15:0] dat_of(int o);
        return (o == 2) ? data2 : ((o == 1) ? data1 : data0);
    endfunction

    function automatic logic [3:0] enm_of(int o);
        return (o == 2) ? enm2 : ((o == 1) ? enm1 : enm0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_own <= 0; m_rr <= 0; m_hc <= 0; m_bc <= 0;
            m_hd <= 1'b0; m_ph <= 1'b1; m_busy <= 1'b0;
            m_gnt <= 3'b000; m_en <= 4'h0; m_d <= 16'h0;
        end else begin
            m_gnt  <= (m_st == 1) ? (3'b001 << m_own) : 3'b000;
            m_busy <= (m_st == 1);
            m_en   <= (m_gnt != 0 && !(blink[m_own] && !m_ph)) ? enm_of(m_own) : 4'h0;
            m_d    <= (m_gnt != 0) ? dat_of(m_own) : m_d;
            case (m_st)
                0: if (req != 0) begin
                    m_st <= 1; m_own <= rr_pick(m_rr, req);
                    m_hc <= 0; m_hd <= 1'b0; m_bc <= 0; m_ph <= 1'b1;
                end
                1: begin
                    if (!req[m_own] || (m_hd && (req & ~(3'b001 << m_own)) != 0)) m_st <= 2;
                    if (tick) begin
                        if (!m_hd) begin
                            if (m_hc == HOLD - 1) m_hd <= 1'b1;
                            else m_hc <= m_hc + 1;
                        end
                        if (m_bc == BLINK - 1) begin m_bc <= 0; m_ph <= !m_ph; end
                        else m_bc <= m_bc + 1;
                    end
                end
                default: begin
                    m_rr <= (m_own + 1) % 3;
                    if (req != 0) begin
                        m_st <= 1; m_own <= rr_pick((m_own + 1) % 3, req);
                        m_hc <= 0; m_hd <= 1'b0; m_bc <= 0; m_ph <= 1'b1;
                    end else m_st <= 0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        #1 sb.push_back({m_gnt, m_busy, m_en, m_d});
    end

    always @(negedge clk) begin
        if (sb.size() != 0)
            chk("out", {8'h0, gnt_o, busy_o, en_o, d3_o, d2_o, d1_o, d0_o}, {8'h0, sb.pop_front()});
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (4) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_gnt(input string tag, output logic [2:0] g);
        int n = 0;
        while (gnt_o == 3'b000 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_granted"}, 32'(gnt_o != 3'b000), 32'd1);
        g = gnt_o;
    endtask

    task automatic next_grant(output logic [2:0] g, output int blank, output int held);
        int n = 0;
        held  = 0;
        blank = 0;
        while (gnt_o != 3'b000 && n < 120) begin held++; @(negedge clk); n++; end
        while (gnt_o == 3'b000 && n < 120) begin blank++; @(negedge clk); n++; end
        chk("next_grant_in_time", 32'(n < 120), 32'd1);
        g = gnt_o;
    endtask

    logic [2:0] g;
    int         blank, held, changed, on_cnt, off_cnt, bad_en, bad_d;
    logic [2:0] seq3 [3] = '{3'b010, 3'b100, 3'b001};

    initial begin
        rst_n = 1'b0; req = 3'b000; blink = 3'b000;
        data0 = 16'h1234; data1 = 16'h5678; data2 = 16'h9ABC;
        enm0 = 4'hF; enm1 = 4'h7; enm2 = 4'hE;
        repeat (3) @(negedge clk);
        chk("rst_out", {gnt_o, busy_o, en_o, d3_o, d2_o, d1_o, d0_o}, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single requester: latency and indefinite ownership
        req = 3'b001;
        @(negedge clk);
        chk("t1_gnt_lat0", gnt_o, 3'b000);
        @(negedge clk);
        chk("t1_gnt", gnt_o, 3'b001);
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_en_lat", en_o, 4'h0);
        @(negedge clk);
        chk("t1_en", en_o, 4'hF);
        chk("t1_d", {d3_o, d2_o, d1_o, d0_o}, 16'h1234);
        changed = 0;
        repeat (100) begin
            @(negedge clk);
            if (gnt_o != 3'b001) changed++;
        end
        chk("t1_no_switch", changed, 0);

        // Time-slice preemption from a fresh grant
        req = 3'b000;
        repeat (4) @(negedge clk);
        chk("t2_idle", gnt_o, 3'b000);
        req = 3'b001;
        wait_gnt("t2_first", g);
        chk("t2_first", g, 3'b001);
        repeat (3) @(negedge clk);
        req = 3'b101;
        next_grant(g, blank, held);
        chk("t2_to_2", g, 3'b100);
        chk("t2_blank_a", blank, 1);
        next_grant(g, blank, held);
        chk("t2_back_0", g, 3'b001);
        chk("t2_blank_b", blank, 1);
        chk("t2_held", 32'(held >= HOLD * 5 - 3 && held <= HOLD * 5 + 1), 32'd1);

        // All three from reset rotate 0,1,2,0
        req = 3'b000;
        do_reset();
        req = 3'b111;
        wait_gnt("t3_first", g);
        chk("t3_first", g, 3'b001);
        for (int i = 0; i < 3; i++) begin
            next_grant(g, blank, held);
            chk("t3_seq", g, seq3[i]);
            chk("t3_blank", blank, 1);
            chk("t3_held", 32'(held >= HOLD * 5 - 3 && held <= HOLD * 5 + 1), 32'd1);
        end

        // Owner release to idle advances the pointer
        req = 3'b000;
        do_reset();
        req = 3'b010;
        wait_gnt("t4_first", g);
        chk("t4_first", g, 3'b010);
        repeat (5) @(negedge clk);
        req = 3'b000;
        repeat (6) @(negedge clk);
        chk("t4_idle", {gnt_o, busy_o, en_o}, 8'h0);
        req = 3'b101;
        wait_gnt("t4_next", g);
        chk("t4_next", g, 3'b100);

        // Blinking owner 0
        req = 3'b000;
        do_reset();
        blink = 3'b001; enm0 = 4'b0011; data0 = 16'hABCD;
        req = 3'b001;
        wait_gnt("t5", g);
        @(negedge clk);
        chk("t5_first_en", en_o, 4'b0011);
        on_cnt = 0; off_cnt = 0; bad_en = 0; bad_d = 0;
        repeat (40) begin
            @(negedge clk);
            if (en_o == 4'b0011) on_cnt++;
            else if (en_o == 4'b0000) off_cnt++;
            else bad_en++;
            if ({d3_o, d2_o, d1_o, d0_o} != 16'hABCD) bad_d++;
        end
        chk("t5_both_phases", 32'(on_cnt >= 10 && off_cnt >= 10), 32'd1);
        chk("t5_en_values", bad_en, 0);
        chk("t5_d_steady", bad_d, 0);

        // Asynchronous reset mid-grant
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t6_async", {gnt_o, busy_o, en_o, d3_o, d2_o, d1_o, d0_o}, 32'h0);
        req = 3'b010; blink = 3'b000;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_lat0", gnt_o, 3'b000);
        @(negedge clk);
        chk("t6_gnt", gnt_o, 3'b010);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
